// File: rtl/nn_pkg.sv
// Shared types and widths for the neuron-layer sequencing blocks.
package nn_pkg;

    localparam int PATTERN_COUNT_W = 16;
    localparam int SETTLE_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    // Value loaded into the settle timer so capture lands exactly SETTLE edges after accept.
    function automatic logic [SETTLE_CNT_W-1:0] settle_load(input int unsigned settle);
        return SETTLE_CNT_W'(settle - 32'd1);
    endfunction

endpackage

// File: rtl/layer_driver_if.sv
// Pattern-in / result-out handshake bundle of the layer driver.
interface layer_driver_if #(
    parameter int NEURONS     = 4,
    parameter int CONNECTIONS = 2
);
    logic                           in_valid;
    logic                           in_ready;
    logic [NEURONS*CONNECTIONS-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [NEURONS-1:0]             out_data;

    // Host / upstream side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Layer driver side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/layer_driver_settle_timer.sv
// Loadable down-counter that flags done while its count is zero.
module settle_timer
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [SETTLE_CNT_W-1:0] load_val_i,
    input  logic                    dec_en_i,
    output logic                    done_o
);

    logic [SETTLE_CNT_W-1:0] cnt_q;
    logic [SETTLE_CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement, decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_en_i && (cnt_q != {SETTLE_CNT_W{1'b0}})) begin
            cnt_d = cnt_q - SETTLE_CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {SETTLE_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == {SETTLE_CNT_W{1'b0}});

endmodule

// File: rtl/layer_driver.sv
// Handshaked sequencing stage: drives a combinational neuron layer for a fixed
// settle interval, then captures and presents the layer outputs.
module layer_driver
    import nn_pkg::*;
#(
    parameter int NEURONS     = 4,
    parameter int CONNECTIONS = 2,
    parameter int SETTLE      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    layer_driver_if.slave                  bus,
    output logic                           neuron_en,
    output logic [NEURONS*CONNECTIONS-1:0] neuron_in,
    input  logic [NEURONS-1:0]             neuron_out,
    output logic [PATTERN_COUNT_W-1:0]     pattern_count
);

    localparam int PW = NEURONS * CONNECTIONS;

    state_e                     state_q, state_d;
    logic                       in_ready_q, in_ready_d;
    logic                       neuron_en_q, neuron_en_d;
    logic [PW-1:0]              neuron_in_q, neuron_in_d;
    logic                       out_valid_q, out_valid_d;
    logic [NEURONS-1:0]         out_data_q, out_data_d;
    logic [PATTERN_COUNT_W-1:0] pattern_count_q, pattern_count_d;
    logic                       load_s;
    logic                       dec_en_s;
    logic                       done_s;

    settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_s),
        .load_val_i (settle_load(SETTLE)),
        .dec_en_i   (dec_en_s),
        .done_o     (done_s)
    );

    assign dec_en_s = (state_q == ST_SETTLE);

    // Next-state and registered-output logic of the IDLE/SETTLE/OUT sequencer
    always_comb begin
        state_d         = state_q;
        in_ready_d      = in_ready_q;
        neuron_en_d     = neuron_en_q;
        neuron_in_d     = neuron_in_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        pattern_count_d = pattern_count_q;
        load_s          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    neuron_in_d = bus.in_data;
                    neuron_en_d = 1'b1;
                    in_ready_d  = 1'b0;
                    load_s      = 1'b1;
                    state_d     = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // Capture while the layer is still enabled; a disabled neuron reads 0
                if (done_s) begin
                    out_data_d      = neuron_out;
                    out_valid_d     = 1'b1;
                    neuron_en_d     = 1'b0;
                    pattern_count_d = pattern_count_q + PATTERN_COUNT_W'(1);
                    state_d         = ST_OUT;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                neuron_en_d = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            in_ready_q      <= 1'b1;
            neuron_en_q     <= 1'b0;
            neuron_in_q     <= {PW{1'b0}};
            out_valid_q     <= 1'b0;
            out_data_q      <= {NEURONS{1'b0}};
            pattern_count_q <= {PATTERN_COUNT_W{1'b0}};
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            neuron_en_q     <= neuron_en_d;
            neuron_in_q     <= neuron_in_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            pattern_count_q <= pattern_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign neuron_en     = neuron_en_q;
    assign neuron_in     = neuron_in_q;
    assign pattern_count = pattern_count_q;

endmodule

// File: tb/tb_layer_driver.sv
// Scoreboard bench for layer_driver with a behavioural neuron layer attached.
module tb_layer_driver;
    import nn_pkg::*;

    localparam int NEURONS     = 4;
    localparam int CONNECTIONS = 2;
    localparam int SETTLE      = 2;
    localparam int PW          = NEURONS * CONNECTIONS;

    typedef struct {
        logic [NEURONS-1:0] data;
        logic [15:0]        cnt;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                neuron_en;
    logic [PW-1:0]       neuron_in;
    logic [NEURONS-1:0]  neuron_out;
    logic [15:0]         pattern_count;

    layer_driver_if #(.NEURONS(NEURONS), .CONNECTIONS(CONNECTIONS)) bus ();

    layer_driver #(.NEURONS(NEURONS), .CONNECTIONS(CONNECTIONS), .SETTLE(SETTLE)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .neuron_en     (neuron_en),
        .neuron_in     (neuron_in),
        .neuron_out    (neuron_out),
        .pattern_count (pattern_count)
    );

    always #5 clk = ~clk;

    // Neuron n fires on odd parity of its inputs, inverted for odd n.
    function automatic logic [NEURONS-1:0] layer_model(input logic [PW-1:0] pat);
        logic [NEURONS-1:0] r;
        for (int n = 0; n < NEURONS; n++) begin
            r[n] = (^pat[n*CONNECTIONS +: CONNECTIONS]) ^ n[0];
        end
        return r;
    endfunction

    always_comb neuron_out = neuron_en ? layer_model(neuron_in) : {NEURONS{1'b0}};

    exp_t          sb_q[$];
    int            checks = 0;
    int            fails = 0;
    int            cyc = 0;
    logic [15:0]   model_cnt = 16'd0;
    bit            pend = 1'b0;
    int            acc_cyc = 0;
    logic [PW-1:0] acc_pat = '0;
    bit            prev_ov = 1'b0;
    bit            stream_phase = 1'b0;
    int            last_hs = -1;
    int            acc_total = 0;
    bit            en_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            pend      = 1'b0;
            model_cnt = 16'd0;
            prev_ov   = 1'b0;
            last_hs   = -1;
        end else begin
            en_exp = pend && ((cyc - acc_cyc) >= 1) && ((cyc - acc_cyc) <= SETTLE);
            check("neuron_en", neuron_en, en_exp);
            if (en_exp) check("neuron_in", neuron_in, acc_pat);
            if (bus.out_valid) begin
                check("in_ready_while_out_valid", bus.in_ready, 1'b0);
                if (!prev_ov && pend) begin
                    check("settle_latency", cyc - acc_cyc, SETTLE + 1);
                    pend = 1'b0;
                end
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result: got out_data %0h, expected no result (cycle %0d)",
                             bus.out_data, cyc);
                end else begin
                    check("out_data", bus.out_data, sb_q[0].data);
                    if (bus.out_ready) begin
                        check("pattern_count", pattern_count, sb_q[0].cnt);
                        void'(sb_q.pop_front());
                        if (stream_phase && last_hs >= 0) check("stream_period", cyc - last_hs, SETTLE + 2);
                        last_hs = stream_phase ? cyc : -1;
                    end
                end
            end
            prev_ov = bus.out_valid;
            if (bus.in_valid && bus.in_ready) begin
                model_cnt = model_cnt + 16'd1;
                sb_q.push_back('{layer_model(bus.in_data), model_cnt});
                pend      = 1'b1;
                acc_cyc   = cyc;
                acc_pat   = bus.in_data;
                acc_total++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_neuron_en", neuron_en, 1'b0);
        check("rst_neuron_in", neuron_in, 8'h00);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 4'h0);
        check("rst_pattern_count", pattern_count, 16'h0000);
    endtask

    task automatic wait_empty(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: got %0d results outstanding, expected 0", name, sb_q.size());
            sb_q.delete();
        end
        tick(1);
    endtask

    task automatic send_one(input logic [PW-1:0] pat);
        bus.in_data  = pat;
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        bus.in_data  = PW'($urandom);
    endtask

    initial begin
        int t;
        int target;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_reset_vals();
        end

        // Single known pattern
        bus.out_ready = 1'b1;
        send_one(8'h1B);
        wait_empty("single");
        check("single_count", pattern_count, 16'd1);

        // Backpressure with ignored input pulses
        bus.out_ready = 1'b0;
        send_one(PW'($urandom));
        t = 0;
        while (!bus.out_valid && t < 20) begin
            tick(1);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = PW'($urandom);
            tick(1);
            check("bp_out_valid_held", bus.out_valid, 1'b1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty("backpressure");

        // Back-to-back stream
        stream_phase = 1'b1;
        target       = acc_total + 4;
        bus.in_valid = 1'b1;
        t = 0;
        while (acc_total < target && t < 100) begin
            bus.in_data = PW'($urandom);
            tick(1);
            t++;
        end
        bus.in_valid = 1'b0;
        wait_empty("stream");
        stream_phase = 1'b0;
        check("stream_count", pattern_count, 16'd6);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_data   = PW'($urandom);
            tick(1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_empty("random");

        // Reset one edge after accept discards the in-flight pattern
        send_one(PW'($urandom));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_reset_vals();
        tick(10);

        // Counter wrap
        dut.pattern_count_q = 16'hFFFE;
        model_cnt = 16'hFFFE;
        tick(1);
        send_one(PW'($urandom));
        wait_empty("wrap_a");
        send_one(PW'($urandom));
        wait_empty("wrap_b");
        check("wrap_count", pattern_count, 16'h0000);

        tick(5);
        check("final_queue_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/layer_driver.md
# layer_driver

Sequencing stage that sits directly upstream of a layer of `Neuron` instances and also captures their outputs. Accepts one input pattern per valid/ready handshake and drives each neuron's `in` bus and `enable`. After a fixed settle interval it registers the layer's outputs and presents them on a valid/ready output port. It turns the combinational neuron layer into a handshaked pipeline stage that downstream layers or the host can consume.

## Interface
Parameters:
- `NEURONS`, 4, number of neurons in the driven layer.
- `CONNECTIONS`, 2, inputs per neuron; must match the `Neuron` instances.
- `SETTLE`, 2, cycles `neuron_en` is held high before capture; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `in_valid`  in  1  input pattern valid.
- `in_ready`  out  1  block can accept a pattern.
- `in_data`  in  NEURONS*CONNECTIONS  pattern; slice [n*CONNECTIONS +: CONNECTIONS] feeds neuron n.
- `neuron_en`  out  1  drives every neuron's `enable`.
- `neuron_in`  out  NEURONS*CONNECTIONS  registered copy of accepted `in_data`.
- `neuron_out`  in  NEURONS  bit n = `out` of neuron n.
- `out_valid`  out  1  captured result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_data`  out  NEURONS  captured `neuron_out`.
- `pattern_count`  out  16  number of captures since reset.

## Operation
- FSM with three states: IDLE, SETTLE, OUT.
- IDLE: `in_ready`=1 and `neuron_en`=0. On `in_valid`&&`in_ready`:
  - latch `in_data` into `neuron_in`;
  - set `neuron_en`=1;
  - load settle counter with SETTLE-1;
  - go to SETTLE.
- SETTLE: `in_ready`=0 and `neuron_en`=1.
  - If counter≠0, decrement it.
  - If counter=0, on this edge: capture `neuron_out` into `out_data`, set `out_valid`=1, clear `neuron_en`, increment `pattern_count`, and go to OUT.
- OUT: `out_valid`=1, `in_ready`=0, `neuron_en`=0, and `out_data` is held stable.
  - On `out_ready`, clear `out_valid` and go to IDLE.
- `neuron_in` holds the last accepted pattern until the next accept; it is not cleared on return to IDLE.
- `pattern_count` wraps from 0xFFFF to 0x0000 with no flag.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside OUT.
- `in_data` changes while not ready have no effect.
- Reset values: state IDLE, `in_ready`=1, `neuron_en`=0, `neuron_in`=0, `out_valid`=0, `out_data`=0, `pattern_count`=0, settle counter 0.

## Timing
- Accept edge E0 → `neuron_en` high from E0 through edge E0+SETTLE (exactly SETTLE cycles high).
- Capture occurs at edge E0+SETTLE. `out_valid` is visible during the following cycle.
- `neuron_out` is sampled only while `neuron_en`=1. A disabled neuron outputs 0, so capture must never occur with `neuron_en` low.
- If `out_ready` is already high when `out_valid` rises, the handshake completes at the next edge, so `out_valid` is high for exactly 1 cycle.
- `in_ready` rises in the cycle after the output handshake. There is a one-cycle bubble, so minimum period is SETTLE+2 cycles per pattern.
- Simultaneous `out_ready` and `in_valid` in OUT: only the output handshake completes; the input waits for IDLE.
- `rst` mid-operation, in any state: at that edge all outputs take their reset values and any in-flight result is discarded.
- `rst` has priority over every handshake in the same cycle.
- `SETTLE`=1: capture occurs on the edge after accept.

## Structure
- Shared package `nn_pkg` holds:
  - the FSM state type (IDLE/SETTLE/OUT, 2-bit encoding);
  - `PATTERN_COUNT_W`=16;
  - the settle-counter width (8 bits).
- Natural sub-module: `settle_timer`, a loadable down-counter with a `done` output when it reaches 0. `layer_driver` instantiates it once.
- The neuron layer itself is instantiated outside this block (generate loop of `Neuron`).

## Test plan
Defaults: NEURONS=4, CONNECTIONS=2, SETTLE=2, with a behavioural neuron model connected.
- Reset then idle: all outputs at reset values, `in_ready`=1 for 10 cycles with no activity.
- Single pattern: `in_data`=8'b00_01_10_11 accepted at edge E0.
  - `neuron_in`=8'h1B and `neuron_en`=1 for edges E0+1..E0+2.
  - `out_valid`=1 after E0+2 with `out_data` = model result.
  - `pattern_count`=1.
- Backpressure: `out_ready` low for 5 cycles. `out_data` stays stable, `out_valid` stays 1, `in_ready` stays 0, and `in_valid` pulses are ignored.
- Back-to-back stream: 4 patterns, with `in_valid` and `out_ready` tied high.
  - One result every 4 cycles.
  - `pattern_count` reaches 4.
  - Results appear in order.
- Reset mid-SETTLE: assert `rst` at edge E0+1. Next cycle `neuron_en`=0, `out_valid`=0, `pattern_count`=0, and no capture appears later.
- Wrap: preload 65535 patterns (or force the count). The next capture yields `pattern_count`=0.
